multi_edge_detector: RTL

Per-channel edge detector, generalising the single-bit rising-edge pulser to WIDTH channels. Each channel has:
- an optional synchroniser
- a stability (debounce) filter
- independent rise/fall enables
- a sticky status flag with write-1-to-clear

The block sits between raw GPIO/handshake inputs and the interrupt/event fabric. It produces single-cycle pulses, per-channel status and an aggregated interrupt.

---
 rtl/edge_det_pkg.sv | 17 +
 rtl/multi_edge_detector_if.sv | 24 ++
 rtl/edge_det_chan.sv | 86 ++++++++
 rtl/multi_edge_detector.sv | 76 +++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared constants, types and helpers for the multi-channel edge detector.
package edge_det_pkg;

    localparam int MAX_SYNC_STAGES = 3;

    // Kind of enabled accept event a channel reports on the current edge.
    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_kind_e;

    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Channel inputs, enables, clear strobes and event outputs of the edge detector.
interface multi_edge_detector_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] status;
    logic             irq;

    modport master (
        output din, rise_en, fall_en, status_clr,
        input  rise_pulse, fall_pulse, level, status, irq
    );

    modport slave (
        input  din, rise_en, fall_en, status_clr,
        output rise_pulse, fall_pulse, level, status, irq
    );
endinterface

// File: rtl/edge_det_chan.sv
// One channel: optional synchroniser, stability filter and registered edge pulses.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES   = 0,
    parameter int STABLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       din,
    input  logic       rise_en,
    input  logic       fall_en,
    output logic       level,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output edge_kind_e ev
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s;
    logic          level_reg;
    logic [CW-1:0] cnt_reg;
    logic          rise_pulse_reg;
    logic          fall_pulse_reg;
    logic          differ;
    logic          accept;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg[0] <= din;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_reg[k] <= sync_reg[k-1];
                    end
                end
            end
            assign s = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    // A new level is accepted only after STABLE_CYCLES consecutive differing samples.
    assign differ = (s != level_reg);
    assign accept = differ && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_reg      <= 1'b0;
            cnt_reg        <= '0;
            rise_pulse_reg <= 1'b0;
            fall_pulse_reg <= 1'b0;
        end else begin
            if (!differ) begin
                cnt_reg <= '0;
            end else if (accept) begin
                level_reg <= s;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            rise_pulse_reg <= accept &&  s && rise_en;
            fall_pulse_reg <= accept && !s && fall_en;
        end
    end

    always_comb begin
        ev = EDGE_NONE;
        if (accept && s && rise_en) begin
            ev = EDGE_RISE;
        end else if (accept && !s && fall_en) begin
            ev = EDGE_FALL;
        end
    end

    assign level      = level_reg;
    assign rise_pulse = rise_pulse_reg;
    assign fall_pulse = fall_pulse_reg;

endmodule

// File: rtl/multi_edge_detector.sv
// WIDTH independent edge-detector channels with sticky W1C status and aggregated irq.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 0,
    parameter int STABLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    multi_edge_detector_if.slave  bus
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("multi_edge_detector: WIDTH must be >= 1");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
            $error("multi_edge_detector: SYNC_STAGES must be 0..3");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("multi_edge_detector: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] level_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;
    logic [WIDTH-1:0] status_reg;
    logic [WIDTH-1:0] status_next;
    edge_kind_e       ev_vec [WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            edge_det_chan #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_CYCLES (STABLE_CYCLES)
            ) u_chan (
                .clk        (clk),
                .resetn     (resetn),
                .din        (bus.din[gi]),
                .rise_en    (bus.rise_en[gi]),
                .fall_en    (bus.fall_en[gi]),
                .level      (level_vec[gi]),
                .rise_pulse (rise_vec[gi]),
                .fall_pulse (fall_vec[gi]),
                .ev         (ev_vec[gi])
            );
        end
    endgenerate

    // A new event on the same edge as its clear keeps the flag set.
    always_comb begin
        status_next = status_reg & ~bus.status_clr;
        for (int k = 0; k < WIDTH; k++) begin
            if (ev_vec[k] != EDGE_NONE) begin
                status_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_reg <= '0;
        end else begin
            status_reg <= status_next;
        end
    end

    assign bus.level      = level_vec;
    assign bus.rise_pulse = rise_vec;
    assign bus.fall_pulse = fall_vec;
    assign bus.status     = status_reg;
    assign bus.irq        = |status_reg;

endmodule
